// File: rtl/mul_sched.sv
// mul_sched: round-robin scheduler that owns a shared repeated-addition
// multiplier datapath and returns each product tagged with its requester ID.
module mul_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 16,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic [W-1:0]         bus,
    output logic                 ld_a,
    output logic                 ld_b,
    output logic                 clr_p,
    output logic                 ld_p,
    output logic                 dec_b,
    input  logic                 eqz,
    input  logic [W-1:0]         prod,
    output logic                 done,
    output logic [IDW-1:0]       done_id,
    output logic [W-1:0]         result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LDA  = 2'd1,
        S_LDB  = 2'd2,
        S_ACC  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_rr;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [IDW-1:0]   r_id;
    logic             r_done;
    logic [IDW-1:0]   r_done_id;
    logic [W-1:0]     r_result;

    logic             w_any;
    logic [IDW-1:0]   w_win;
    logic             w_take;
    logic             w_finish;

    // Round-robin search starting at the pointer, wrapping at NREQ.
    always_comb begin : arb
        int unsigned idx;
        w_any = 1'b0;
        w_win = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(r_rr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_any && req[IDW'(idx)]) begin
                w_any = 1'b1;
                w_win = IDW'(idx);
            end
        end
    end

    // A grant is taken only in IDLE; gated by rst_n so gnt is 0 in reset.
    assign w_take   = (r_state == S_IDLE) && w_any && rst_n;
    assign w_finish = (r_state == S_ACC) && eqz;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes decoded from the current state.
    always_comb begin
        w_state_nxt = r_state;
        gnt         = '0;
        bus         = '0;
        ld_a        = 1'b0;
        ld_b        = 1'b0;
        clr_p       = 1'b0;
        ld_p        = 1'b0;
        dec_b       = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    gnt         = NREQ'(1) << w_win;
                    w_state_nxt = S_LDA;
                end
            end
            S_LDA: begin
                bus         = r_a;
                ld_a        = 1'b1;
                w_state_nxt = S_LDB;
            end
            S_LDB: begin
                bus         = r_b;
                ld_b        = 1'b1;
                clr_p       = 1'b1;
                w_state_nxt = S_ACC;
            end
            S_ACC: begin
                if (!eqz) begin
                    ld_p  = 1'b1;
                    dec_b = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latch winner operands and ID, and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= '0;
            r_a  <= '0;
            r_b  <= '0;
            r_id <= '0;
        end else if (w_take) begin
            r_a  <= req_a[32'(w_win)*W +: W];
            r_b  <= req_b[32'(w_win)*W +: W];
            r_id <= w_win;
            r_rr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
        end
    end

    // Registered result strobe, ID and product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_result  <= '0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_done_id <= r_id;
                r_result  <= prod;
            end
        end
    end

    assign done    = r_done;
    assign done_id = r_done_id;
    assign result  = r_result;

endmodule
